// File: rtl/uart_count_streamer.sv
// Streams a stepped DATA_W-bit counter to an 8N1 UART as binary bytes or ASCII hex + CR LF.
// Each byte is held on tx_data from LOAD through DRAIN; frames always complete once started.
module uart_count_streamer #(
    parameter int DATA_W     = 16,
    parameter int MODE       = 0,
    parameter int GAP_CYCLES = 1048576,
    parameter int GAP_W      = 21
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [DATA_W-1:0] step,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic [DATA_W-1:0] count,
    output logic              frame_done,
    output logic              active
);

    localparam int ND = (DATA_W + 3) / 4;
    localparam int NB = (MODE == 0) ? (DATA_W + 7) / 8 : ND + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_REQ,
        S_DRAIN,
        S_GAP
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_count;
    logic [DATA_W-1:0] r_snap;
    logic [3:0]        r_idx;
    logic [GAP_W-1:0]  r_gap;
    logic              r_tx_start;
    logic [7:0]        r_tx_data;
    logic              r_frame_done;
    logic              r_active;

    logic [39:0]       w_pad;
    int                w_pos;
    logic [3:0]        w_nib;
    logic [7:0]        w_sel;
    logic              w_last;

    assign w_last = (r_idx == 4'(NB - 1));

    // Byte for the current index, MSB-first from the zero-extended snapshot.
    always_comb begin
        w_pad = 40'(r_snap);
        w_pos = 0;
        w_nib = 4'h0;
        w_sel = 8'h00;
        if (MODE == 0) begin
            w_pos = 8 * (NB - 1 - int'(r_idx));
            if (w_pos < 0) w_pos = 0;
            w_sel = 8'(w_pad >> w_pos);
        end else begin
            if (r_idx < 4'(ND)) begin
                w_pos = 4 * (ND - 1 - int'(r_idx));
                if (w_pos < 0) w_pos = 0;
                w_nib = 4'(w_pad >> w_pos);
                w_sel = (w_nib < 4'd10) ? 8'h30 + {4'h0, w_nib} : 8'h37 + {4'h0, w_nib};
            end else if (r_idx == 4'(ND)) begin
                w_sel = 8'h0D;
            end else begin
                w_sel = 8'h0A;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_count      <= '0;
            r_snap       <= '0;
            r_idx        <= 4'd0;
            r_gap        <= '0;
            r_tx_start   <= 1'b0;
            r_tx_data    <= 8'h00;
            r_frame_done <= 1'b0;
            r_active     <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_snap   <= r_count;
                        r_idx    <= 4'd0;
                        r_active <= 1'b1;
                        r_state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_tx_data  <= w_sel;
                    r_tx_start <= 1'b1;
                    r_state    <= S_REQ;
                end
                S_REQ: begin
                    // A UART already busy on entry counts as acceptance.
                    if (tx_busy) begin
                        r_tx_start <= 1'b0;
                        r_state    <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!tx_busy) begin
                        if (w_last) begin
                            r_count      <= r_count + step;
                            r_frame_done <= 1'b1;
                            r_idx        <= 4'd0;
                            if (enable) begin
                                r_state <= S_GAP;
                            end else begin
                                r_state  <= S_IDLE;
                                r_active <= 1'b0;
                            end
                        end else begin
                            r_idx   <= r_idx + 4'd1;
                            r_state <= S_LOAD;
                        end
                    end
                end
                S_GAP: begin
                    if (!enable) begin
                        r_gap    <= '0;
                        r_state  <= S_IDLE;
                        r_active <= 1'b0;
                    end else if (r_gap == GAP_W'(GAP_CYCLES - 1)) begin
                        r_gap   <= '0;
                        r_snap  <= r_count;
                        r_state <= S_LOAD;
                    end else begin
                        r_gap <= r_gap + GAP_W'(1);
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_active <= 1'b0;
                end
            endcase
        end
    end

    assign tx_start   = r_tx_start;
    assign tx_data    = r_tx_data;
    assign count      = r_count;
    assign frame_done = r_frame_done;
    assign active     = r_active;

endmodule

// File: doc/uart_count_streamer.md
Name: uart_count_streamer

Overview:
- Parametrised successor to the single-byte UART counter demo.
- Keeps a DATA_W-bit counter, advances it by a programmable step after every frame, and streams each value to the existing 8N1 UART transmitter.
- Frame format is selectable: raw binary bytes, MSB first, or uppercase ASCII hex followed by CR LF.
- Sits between top-level control and the uart_tx_8n1 start/data/busy interface; drives that interface directly.

Parameters:
- DATA_W, 16: counter width in bits, 1..32.
- MODE, 0: 0 = binary frame, 1 = ASCII hex frame.
- GAP_CYCLES, 1048576: idle clk cycles between frames, >= 1.
- GAP_W, 21: gap counter width; must satisfy 2^GAP_W >= GAP_CYCLES.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  level; 1 = stream frames continuously.
- step  in  DATA_W  increment applied at end of each frame.
- tx_busy  in  1  busy flag from uart_tx_8n1.
- tx_start  out  1  send request to UART (its send-enable).
- tx_data  out  8  byte to transmit.
- count  out  DATA_W  current counter value.
- frame_done  out  1  one-cycle pulse when the last byte of a frame completes.
- active  out  1  high whenever state != IDLE.

Behaviour:
- Reset, asynchronous, any state: state=IDLE, count=0, tx_start=0, tx_data=0, frame_done=0, active=0, gap counter=0, byte index=0.
- Frame length in bytes, fixed at elaboration:
  - NB = ceil(DATA_W/8) for MODE 0.
  - NB = ceil(DATA_W/4)+2 for MODE 1.
- Byte content, taken from a snapshot of count latched on IDLE/GAP -> LOAD:
  - MODE 0: byte i = bits of the snapshot, MSB-first. The top byte is zero-extended when DATA_W is not a multiple of 8.
  - MODE 1: nibble i, MSB-first, encoded as '0'-'9' = 0x30-0x39 and 'A'-'F' = 0x41-0x46. The snapshot is zero-extended to a multiple of 4 bits. Digits are followed by 0x0D, then 0x0A.
- State machine:
  - IDLE: if enable=1, go to LOAD (first frame has no leading gap).
  - LOAD: present tx_data for the current index; go to REQ next cycle.
  - REQ: tx_start=1. tx_data is held stable for the whole REQ/DRAIN span. When tx_busy=1, drop tx_start the same edge and go to DRAIN.
  - DRAIN: tx_start=0, wait for tx_busy=0.
    - Not last byte: index++, go to LOAD.
    - Last byte: count <= count + step (mod 2^DATA_W, wraps silently), pulse frame_done, index=0. Go to GAP if enable=1, else IDLE.
  - GAP: gap counter counts 0..GAP_CYCLES-1. On reaching GAP_CYCLES-1, clear it and go to LOAD if enable=1, else IDLE.
  - enable=0 during GAP returns to IDLE immediately.
- enable deasserted mid-frame (LOAD/REQ/DRAIN): the frame always completes, then the FSM goes to IDLE. Frames are never truncated.
- step is sampled only on the edge that updates count. Changing step mid-frame affects that frame's update only if it is stable on that edge.
- count changes only at frame end, so the transmitted value always equals count as of frame start.
- tx_busy already 1 on entry to REQ (UART not idle): treated as acceptance. The bench UART model must idle low; this is a documented constraint, not a checked error.
- Latency: count advances 1 cycle after the final tx_busy falling edge is seen. frame_done is registered and coincides with the count update.

Test Plan:
- Reset mid-frame: assert rst_n=0 while in REQ -> tx_start=0, count=0, active=0 in the same cycle, with no clock edge needed.
- MODE 0, DATA_W=16, step=1, GAP_CYCLES=4, UART model busy 2 cycles after start for 10 cycles:
  - Frames are 0x00 0x00, then 0x00 0x01, then 0x00 0x02.
  - frame_done pulses once per frame.
  - Exactly 4 idle cycles between the last DRAIN exit and the next LOAD.
- MODE 1, DATA_W=12, step=0x123, count starting at 0: second frame is "123\r\n" = 0x31 0x32 0x33 0x0D 0x0A; third frame is "246\r\n".
- Wrap: DATA_W=8, MODE 0, step=0xFF, count=0x02 -> next count 0x01. Frame bytes are 0x02, then 0x01.
- enable dropped during the 2nd byte of a 2-byte frame: that byte still transmits, count increments once, FSM goes to IDLE with active=0 and no further tx_start.
- Handshake integrity: hold tx_busy=0 for 50 cycles in REQ -> tx_start stays 1 and tx_data stays constant. Raise tx_busy -> tx_start=0 on the next edge.
